// File: rtl/uart_byte_capture.sv
// 8N1 UART receiver feeding the two-digit display: synchronises rx, validates each
// frame and holds the last good byte on `value` with single-cycle status pulses.
module uart_byte_capture #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] value,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int N  = CLKS_PER_BIT;
    localparam int H  = (N - 1) / 2;
    localparam int CW = $clog2(N);

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    // START is entered one edge after s2 falls; stopping at H-1 puts the start-bit
    // check H edges after entry, so every later sample sits mid-bit.
    localparam logic [CW-1:0] CNT_MID  = CW'(H - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    logic          s1_q;
    logic          s2_q;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    sr_q;
    logic [7:0]    value_q;
    logic          byte_valid_q;
    logic          frame_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= rx;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sr_q         <= '0;
            value_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!s2_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (cnt_q != CNT_MID) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else if (!s2_q) begin
                        state_q <= DATA;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        sr_q  <= {s2_q, sr_q[7:1]};
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (s2_q) begin
                            value_q      <= sr_q;
                            byte_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low (break) line must not be re-read as 0x00 frames.
                    if (s2_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign value      = value_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_byte_capture.sv
// Directed bench for uart_byte_capture at 4 clocks per bit: frame timing, glitch
// rejection, framing errors, back-to-back frames and mid-frame reset.
module tb_uart_byte_capture;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] value;
    logic       byte_valid;
    logic       frame_err;

    int checks = 0;
    int errs   = 0;
    int cyc    = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int bv_t[$];

    uart_byte_capture #(.CLKS_PER_BIT(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .value     (value),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (byte_valid === 1'b1) begin
            bv_cnt++;
            bv_t.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (byte_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the caller just after the stop-sample edge (edge 39 at N=4).
    task automatic send(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(N);
        end
        rx = stop_bit;
        tick(N);
    endtask

    initial begin
        int b;
        int f;
        logic [7:0] d55;

        reset = 1'b1;
        rx    = 1'b1;
        tick(3);
        check("rst_value", value, 8'h00);
        check("rst_bv", byte_valid, 1'b0);
        check("rst_fe", frame_err, 1'b0);
        reset = 1'b0;
        tick(100);
        check("idle_no_bv", bv_cnt, 0);
        check("idle_no_fe", fe_cnt, 0);

        b = bv_cnt;
        send(8'hA5, 1'b1);
        check("a5_pulse", byte_valid, 1'b1);
        check("a5_value", value, 8'hA5);
        tick(1);
        check("a5_pulse_end", byte_valid, 1'b0);
        check("a5_single", bv_cnt - b, 1);
        check("a5_no_fe", fe_cnt, 0);
        tick(5);

        b = bv_cnt;
        f = fe_cnt;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(30);
        check("glitch_no_bv", bv_cnt - b, 0);
        check("glitch_no_fe", fe_cnt - f, 0);
        check("glitch_value", value, 8'hA5);

        b = bv_cnt;
        send(8'h3C, 1'b0);
        check("ferr_pulse", frame_err, 1'b1);
        check("ferr_no_bv", byte_valid, 1'b0);
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(10);
        check("ferr_once", fe_cnt - f, 1);
        check("ferr_bv_none", bv_cnt - b, 0);
        check("ferr_value", value, 8'hA5);
        send(8'h7E, 1'b1);
        check("7e_pulse", byte_valid, 1'b1);
        check("7e_value", value, 8'h7E);
        tick(5);

        b = bv_t.size();
        send(8'h00, 1'b1);
        check("b2b_00", value, 8'h00);
        send(8'hFF, 1'b1);
        check("b2b_ff", value, 8'hFF);
        send(8'h81, 1'b1);
        check("b2b_81", value, 8'h81);
        check("b2b_81_pulse", byte_valid, 1'b1);
        tick(1);
        check("b2b_count", bv_t.size() - b, 3);
        if (bv_t.size() >= b + 3) begin
            check("b2b_gap1", bv_t[b+1] - bv_t[b], 40);
            check("b2b_gap2", bv_t[b+2] - bv_t[b+1], 40);
        end
        tick(5);

        send(8'h12, 1'b1);
        check("pre_rst_12", value, 8'h12);
        tick(3);
        b = bv_cnt;
        f = fe_cnt;
        d55 = 8'h55;
        rx = 1'b0;
        tick(N);
        for (int i = 0; i < 4; i++) begin
            rx = d55[i];
            tick(N);
        end
        rx = d55[4];
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_value", value, 8'h00);
        reset = 1'b0;
        rx    = 1'b1;
        tick(60);
        check("midrst_no_bv", bv_cnt - b, 0);
        check("midrst_no_fe", fe_cnt - f, 0);
        send(8'h99, 1'b1);
        check("99_pulse", byte_valid, 1'b1);
        check("99_value", value, 8'h99);
        tick(5);

        check("never_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
